// File: rtl/osd_io_bridge_if.sv
// HPS-side write bus and OSD-side byte bus of the OSD I/O bridge.
// Handshake: a word transfers on a clk_sys edge where hps_en & hps_strobe
// & hps_ready are all high; hps_ready depends only on bridge state, never
// on hps_strobe. A word offered while hps_ready is low is dropped, not held.
// dbg_state mirrors the serialiser FSM state for observation.
interface osd_io_bridge_if;
    logic        hps_en;
    logic        hps_strobe;
    logic [15:0] hps_din;
    logic        hps_wide;
    logic        hps_ready;
    logic        io_osd;
    logic        io_strobe;
    logic [7:0]  io_din;
    logic [2:0]  dbg_state;

    modport master (
        output hps_en, hps_strobe, hps_din, hps_wide,
        input  hps_ready, io_osd, io_strobe, io_din, dbg_state
    );

    modport slave (
        input  hps_en, hps_strobe, hps_din, hps_wide,
        output hps_ready, io_osd, io_strobe, io_din, dbg_state
    );
endinterface

// File: rtl/osd_io_bridge.sv
// osd_io_bridge: buffers HPS 16-bit OSD writes in a word FIFO and replays
// them as the byte-wide io_osd/io_strobe/io_din protocol with guaranteed
// strobe spacing and a closing io_osd low gap.
// Optional build macro OSD_IO_BRIDGE_OVF_EN adds the ovf/ovf_cnt outputs.
module osd_io_bridge #(
    parameter int FIFO_DEPTH = 8,
    parameter int STROBE_GAP = 1,
    parameter int CLOSE_GAP  = 2
) (
    input  logic           clk_sys,
    input  logic           reset_n,
    osd_io_bridge_if.slave bus
`ifdef OSD_IO_BRIDGE_OVF_EN
    ,
    output logic           ovf,
    output logic [7:0]     ovf_cnt
`endif
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int PW   = AW + 1;
    localparam int GMAX = (STROBE_GAP > CLOSE_GAP) ? STROBE_GAP : CLOSE_GAP;
    localparam int CW   = $clog2(GMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_OPEN  = 3'd1,
        S_STB   = 3'd2,
        S_GAP   = 3'd3,
        S_WAIT  = 3'd4,
        S_CLOSE = 3'd5
    } state_t;

    // FIFO entry: {marker, wide, data[15:0]}
    logic [17:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
    logic [AW-1:0] rd_idx, nx_idx;
    logic [17:0]   head;
    logic          head_mark, head_wide, next_mark;
    logic          fifo_empty, fifo_full, has_next, ready;
    logic          push_word, push_mark, push, pop;
    logic          hps_en_q;

    state_t        state_q, state_d;
    logic          hi_q, hi_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          gap_done, close_done;

    logic          io_osd_q, io_osd_d, io_strobe_q, io_strobe_d;
    logic [7:0]    io_din_q, io_din_d;

    assign rd_idx     = rd_ptr_q[AW-1:0];
    assign nx_idx     = rd_idx + AW'(1);
    assign head       = mem_q[rd_idx];
    assign head_mark  = head[17];
    assign head_wide  = head[16];
    assign next_mark  = mem_q[nx_idx][17];
    assign fifo_empty = (count_q == '0);
    assign has_next   = (count_q > PW'(1));
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_idx);

    // One slot stays free so the end-of-transaction marker always fits.
    assign ready     = (count_q < PW'(FIFO_DEPTH - 1));
    assign push_word = bus.hps_strobe & bus.hps_en & ready;
    assign push_mark = hps_en_q & ~bus.hps_en & ~fifo_full;
    assign push      = push_word | push_mark;

    assign gap_done   = (cnt_q == CW'(STROBE_GAP - 1));
    assign close_done = (cnt_q == CW'(CLOSE_GAP - 1));

    // FIFO pointer/count next-state arithmetic
    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + PW'(push) - PW'(pop);
    end

    // FIFO bookkeeping and hps_en edge detector; reset discards all entries
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            hps_en_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            hps_en_q <= bus.hps_en;
        end
    end

    // FIFO storage; a marker push wins over a word in the same cycle
    always_ff @(posedge clk_sys) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {push_mark, bus.hps_wide, bus.hps_din};
        end
    end

    // FSM state register plus byte-half flag and gap counter
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            hi_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM next state and FIFO pop; after a word, a queued next word goes
    // straight to STB so strobe spacing inside a burst stays 1+STROBE_GAP
    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    if (head_mark) pop = 1'b1;
                    else           state_d = S_OPEN;
                end
            end
            S_OPEN: state_d = S_STB;
            S_STB:  state_d = S_GAP;
            S_GAP: begin
                if (gap_done) begin
                    if (!hi_q && head_wide) begin
                        hi_d    = 1'b1;
                        state_d = S_STB;
                    end else begin
                        pop     = 1'b1;
                        hi_d    = 1'b0;
                        state_d = (has_next && !next_mark) ? S_STB : S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!fifo_empty) begin
                    if (head_mark) begin
                        pop     = 1'b1;
                        state_d = S_CLOSE;
                    end else begin
                        state_d = S_STB;
                    end
                end
            end
            S_CLOSE: if (close_done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Residence counter for the timed GAP and CLOSE states
    always_comb begin
        cnt_d = '0;
        if ((state_q == S_GAP || state_q == S_CLOSE) && state_d == state_q) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Output decode; registered below so io_osd leads the first strobe by one cycle
    always_comb begin
        io_osd_d    = (state_q == S_OPEN) || (state_q == S_STB) ||
                      (state_q == S_GAP)  || (state_q == S_WAIT);
        io_strobe_d = (state_q == S_STB);
        io_din_d    = io_din_q;
        if (state_q == S_STB) begin
            io_din_d = hi_q ? head[15:8] : head[7:0];
        end
    end

    // Output registers; reset drops io_osd and io_strobe immediately
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            io_osd_q    <= 1'b0;
            io_strobe_q <= 1'b0;
            io_din_q    <= 8'h00;
        end else begin
            io_osd_q    <= io_osd_d;
            io_strobe_q <= io_strobe_d;
            io_din_q    <= io_din_d;
        end
    end

    assign bus.hps_ready = ready;
    assign bus.io_osd    = io_osd_q;
    assign bus.io_strobe = io_strobe_q;
    assign bus.io_din    = io_din_q;
    assign bus.dbg_state = state_q;

`ifdef OSD_IO_BRIDGE_OVF_EN
    logic       drop;
    logic       ovf_q;
    logic [7:0] ovf_cnt_q;

    assign drop = bus.hps_strobe & bus.hps_en & ~ready;

    // Sticky overflow flag and saturating dropped-word count
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q     <= 1'b0;
            ovf_cnt_q <= 8'h00;
        end else begin
            ovf_q <= ovf_q | drop;
            if (drop && ovf_cnt_q != 8'hFF) ovf_cnt_q <= ovf_cnt_q + 8'd1;
        end
    end

    assign ovf     = ovf_q;
    assign ovf_cnt = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_osd_io_bridge.sv
`timescale 1ns/1ps
module tb_osd_io_bridge;
    localparam int DEPTH = 8;
    localparam int SG    = 1;
    localparam int CG    = 2;

    // ---------------- clock / reset ----------------
    logic clk_sys = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    osd_io_bridge_if bus_if();
`ifdef OSD_IO_BRIDGE_OVF_EN
    logic       ovf;
    logic [7:0] ovf_cnt;
`endif

    osd_io_bridge #(.FIFO_DEPTH(DEPTH), .STROBE_GAP(SG), .CLOSE_GAP(CG)) dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .bus     (bus_if)
`ifdef OSD_IO_BRIDGE_OVF_EN
        ,
        .ovf     (ovf),
        .ovf_cnt (ovf_cnt)
`endif
    );

    // ---------------- scoreboard state ----------------
    // entry: {last byte of word, end of transaction, byte}
    logic [9:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    int n_pushed = 0, n_retired = 0;
    int n_strb = 0, n_win = 0;
    int viol_dbl = 0, viol_sel = 0, viol_din = 0;
    int min_low = 1000, low_run = 0;
    int rise_cyc = -1, first_strb_cyc = -1, last_strb_cyc = 0;
    int min_sp = 1000, max_sp = 0;
    bit win_seen = 1'b0;
    logic prev_osd = 1'b0, prev_strb = 1'b0;
    logic [7:0] prev_din = 8'h00;

    int txn_acc = 0, drops = 0, acc_before_drop = 0, last_push_cyc = 0;
    bit seen_drop = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk_sys) begin
        if (!reset_n) begin
            prev_osd  = 1'b0;
            prev_strb = 1'b0;
            prev_din  = 8'h00;
            low_run   = 0;
        end else begin
            if (bus_if.io_strobe) begin
                logic [9:0] e;
                n_strb++;
                if (prev_strb) viol_dbl++;
                if (!bus_if.io_osd) viol_sel++;
                if (!win_seen) begin
                    first_strb_cyc = cyc;
                    win_seen = 1'b1;
                end else begin
                    if (cyc - last_strb_cyc < min_sp) min_sp = cyc - last_strb_cyc;
                    if (cyc - last_strb_cyc > max_sp) max_sp = cyc - last_strb_cyc;
                end
                last_strb_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("extra_byte", {24'h0, bus_if.io_din}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("byte", {23'h0, 1'b0, bus_if.io_din}, {23'h0, e[8:0]});
                    if (e[9]) n_retired++;
                end
            end
            if (bus_if.io_din != prev_din && !bus_if.io_strobe) viol_din++;
            if (bus_if.io_osd && !prev_osd) begin
                n_win++;
                rise_cyc = cyc;
                win_seen = 1'b0;
                if (low_run < min_low) min_low = low_run;
            end
            if (!bus_if.io_osd && prev_osd) begin
                logic [9:0] e;
                if (exp_q.size() == 0) begin
                    check("extra_close", 32'h1, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    check("txn_end", {23'h0, e[8:0]}, 32'h100);
                    n_retired++;
                end
            end
            // entries certainly still buffered force hps_ready low
            if (n_pushed - n_retired >= DEPTH - 1) check("ready_full", {31'h0, bus_if.hps_ready}, 32'h0);
            low_run   = bus_if.io_osd ? 0 : low_run + 1;
            prev_osd  = bus_if.io_osd;
            prev_strb = bus_if.io_strobe;
            prev_din  = bus_if.io_din;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic start_txn();
        @(negedge clk_sys);
        bus_if.hps_en     = 1'b1;
        bus_if.hps_strobe = 1'b0;
        txn_acc = 0;
        @(posedge clk_sys);
        #1;
    endtask

    task automatic push(input logic [15:0] d, input logic w);
        bit acc;
        @(negedge clk_sys);
        bus_if.hps_strobe = 1'b1;
        bus_if.hps_din    = d;
        bus_if.hps_wide   = w;
        acc = bus_if.hps_ready;
        @(posedge clk_sys);
        #1;
        bus_if.hps_strobe = 1'b0;
        if (acc) begin
            txn_acc++;
            n_pushed++;
            if (!seen_drop) acc_before_drop++;
            last_push_cyc = cyc;
            exp_q.push_back({~w, 1'b0, d[7:0]});
            if (w) exp_q.push_back({1'b1, 1'b0, d[15:8]});
        end else begin
            drops++;
            seen_drop = 1'b1;
        end
    endtask

    task automatic end_txn();
        @(negedge clk_sys);
        bus_if.hps_en     = 1'b0;
        bus_if.hps_strobe = 1'b0;
        @(posedge clk_sys);
        #1;
        if (txn_acc > 0) begin
            exp_q.push_back(10'h100);
            n_pushed++;
        end
    endtask

    task automatic drain();
        int k = 0;
        while ((exp_q.size() != 0 || bus_if.io_osd || bus_if.dbg_state != 3'd0) && k < 500) begin
            @(posedge clk_sys);
            k++;
        end
        #1;
        check("drain_timeout", {31'h0, k < 500}, 32'h1);
        idle(CG + 2);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int w0, s0, nonempty;
        bus_if.hps_en     = 1'b0;
        bus_if.hps_strobe = 1'b0;
        bus_if.hps_din    = 16'h0;
        bus_if.hps_wide   = 1'b0;

        // reset values
        repeat (3) @(posedge clk_sys);
        #1;
        check("rst_ready", {31'h0, bus_if.hps_ready}, 32'h1);
        check("rst_osd", {31'h0, bus_if.io_osd}, 32'h0);
        check("rst_strobe", {31'h0, bus_if.io_strobe}, 32'h0);
        check("rst_din", {24'h0, bus_if.io_din}, 32'h0);
        @(negedge clk_sys);
        reset_n = 1'b1;
        idle(3);

        // enable command: single narrow word, latency checks
        w0 = n_win; s0 = n_strb;
        start_txn();
        push(16'h0041, 1'b0);
        end_txn();
        drain();
        check("cmd_windows", n_win - w0, 1);
        check("cmd_strobes", n_strb - s0, 1);
        check("osd_latency", rise_cyc - last_push_cyc, 2);
        check("strobe_latency", first_strb_cyc - last_push_cyc, 3);

        // write burst: 20, AA, BB, CC, DD with 1+SG spacing
        w0 = n_win; s0 = n_strb; min_sp = 1000; max_sp = 0;
        start_txn();
        push(16'h0020, 1'b0);
        push(16'hBBAA, 1'b1);
        push(16'hDDCC, 1'b1);
        end_txn();
        drain();
        check("burst_windows", n_win - w0, 1);
        check("burst_strobes", n_strb - s0, 5);
        check("burst_min_spacing", min_sp, 1 + SG);
        check("burst_max_spacing", max_sp, 1 + SG);

        // back-to-back transactions separated by one low cycle of hps_en
        w0 = n_win;
        start_txn();
        push(16'($urandom), 1'b1);
        push(16'($urandom), 1'b0);
        end_txn();
        start_txn();
        push(16'($urandom), 1'b0);
        push(16'($urandom), 1'b1);
        end_txn();
        drain();
        check("b2b_windows", n_win - w0, 2);

        // randomized transactions, some empty, some back-to-back
        w0 = n_win; nonempty = 0;
        for (int r = 0; r < 8; r++) begin
            int nw;
            start_txn();
            nw = $urandom_range(0, 4);
            for (int i = 0; i < nw; i++) begin
                push(16'($urandom), 1'($urandom_range(0, 1)));
                if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
            end
            if (nw == 0) idle($urandom_range(1, 2));
            end_txn();
            if (txn_acc > 0) nonempty++;
            if ($urandom_range(0, 1) == 1) drain();
        end
        drain();
        check("rand_windows", n_win - w0, nonempty);

        // overflow: back-to-back wide pushes outrun the serialiser
        w0 = n_win; drops = 0; acc_before_drop = 0; seen_drop = 1'b0;
        start_txn();
        for (int i = 0; i < 14; i++) push(16'($urandom), 1'b1);
        end_txn();
        drain();
        check("ovf_drops_seen", {31'h0, drops > 0}, 32'h1);
        check("ovf_accepted_before_drop", {31'h0, acc_before_drop >= DEPTH - 1}, 32'h1);
        check("ovf_windows", n_win - w0, 1);
`ifdef OSD_IO_BRIDGE_OVF_EN
        check("ovf_flag", {31'h0, ovf}, 32'h1);
        check("ovf_cnt", {24'h0, ovf_cnt}, drops);
`endif

        // empty transaction: io_osd must never rise
        w0 = n_win; s0 = n_strb;
        start_txn();
        idle(2);
        end_txn();
        idle(12);
        check("empty_windows", n_win - w0, 0);
        check("empty_strobes", n_strb - s0, 0);

        // reset mid-burst, during a strobe gap
        start_txn();
        push(16'h1234, 1'b1);
        push(16'h5678, 1'b1);
        push(16'h9ABC, 1'b1);
        end_txn();
        begin
            int k = 0;
            while (!bus_if.io_strobe && k < 50) begin
                @(negedge clk_sys);
                k++;
            end
            check("strobe_timeout", {31'h0, k < 50}, 32'h1);
        end
        @(negedge clk_sys);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_mid_osd", {31'h0, bus_if.io_osd}, 32'h0);
        check("rst_mid_strobe", {31'h0, bus_if.io_strobe}, 32'h0);
        check("rst_mid_ready", {31'h0, bus_if.hps_ready}, 32'h1);
        exp_q.delete();
        n_pushed = 0;
        n_retired = 0;
        repeat (3) @(negedge clk_sys);
        #2;
        reset_n = 1'b1;
        idle(3);
        w0 = n_win; s0 = n_strb;
        start_txn();
        push(16'h0041, 1'b0);
        end_txn();
        drain();
        check("post_rst_windows", n_win - w0, 1);
        check("post_rst_strobes", n_strb - s0, 1);

        // global protocol properties
        check("queue_empty", exp_q.size(), 0);
        check("strobe_back_to_back", viol_dbl, 0);
        check("strobe_without_osd", viol_sel, 0);
        check("din_change_outside_strobe", viol_din, 0);
        check("close_gap", {31'h0, min_low >= CG}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // run-time bound
    initial begin
        #1_000_000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
